// File: rtl/popcount_window_stats.sv
// rtl/popcount_window_stats.sv - per-window sum/min/max/count of a popcount stream with record FIFO
//
// Purpose: groups the incoming popcount stream into windows of WINDOW_LEN
// words (or shorter, closed early by flush_i), computes sum/min/max/word
// count per window and queues completed records in a first-word-fall-through
// FIFO read over a valid/ready interface.
//
// Ports:
//   clk_i, arst_n_i       clock, asynchronous active-low reset
//   cnt_i, cnt_val_i      popcount of one word and its valid strobe
//   flush_i               close the current (non-empty) window early
//   sum_o/min_o/max_o/words_o  head record fields (hold when FIFO empty)
//   stat_val_o            head record valid
//   stat_ready_i          consumer accepts head record
//   drop_o                one-cycle pulse: a completed record was discarded
module popcount_window_stats #(
    parameter int CNT_WIDTH  = 6,
    parameter int WINDOW_LEN = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int WCNT_W    = $clog2(WINDOW_LEN) + 1,
    localparam int SUM_W     = CNT_WIDTH + $clog2(WINDOW_LEN)
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 cnt_val_i,
    input  logic                 flush_i,
    output logic [SUM_W-1:0]     sum_o,
    output logic [CNT_WIDTH-1:0] min_o,
    output logic [CNT_WIDTH-1:0] max_o,
    output logic [WCNT_W-1:0]    words_o,
    output logic                 stat_val_o,
    input  logic                 stat_ready_i,
    output logic                 drop_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    // Window accumulators
    logic [SUM_W-1:0]     acc_sum_q,   acc_sum_d;
    logic [CNT_WIDTH-1:0] acc_min_q,   acc_min_d;
    logic [CNT_WIDTH-1:0] acc_max_q,   acc_max_d;
    logic [WCNT_W-1:0]    acc_words_q, acc_words_d;

    // Record FIFO storage and control
    logic [SUM_W-1:0]     mem_sum_q   [FIFO_DEPTH];
    logic [SUM_W-1:0]     mem_sum_d   [FIFO_DEPTH];
    logic [CNT_WIDTH-1:0] mem_min_q   [FIFO_DEPTH];
    logic [CNT_WIDTH-1:0] mem_min_d   [FIFO_DEPTH];
    logic [CNT_WIDTH-1:0] mem_max_q   [FIFO_DEPTH];
    logic [CNT_WIDTH-1:0] mem_max_d   [FIFO_DEPTH];
    logic [WCNT_W-1:0]    mem_words_q [FIFO_DEPTH];
    logic [WCNT_W-1:0]    mem_words_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     occ_q,    occ_d;

    // Registered output view of the head record
    logic [SUM_W-1:0]     out_sum_q,   out_sum_d;
    logic [CNT_WIDTH-1:0] out_min_q,   out_min_d;
    logic [CNT_WIDTH-1:0] out_max_q,   out_max_d;
    logic [WCNT_W-1:0]    out_words_q, out_words_d;
    logic                 out_val_q,   out_val_d;
    logic                 drop_q,      drop_d;

    // Window contents including this cycle's word
    logic [SUM_W-1:0]     win_sum;
    logic [CNT_WIDTH-1:0] win_min;
    logic [CNT_WIDTH-1:0] win_max;
    logic [WCNT_W-1:0]    win_words;
    logic                 close_w;
    logic                 pop_w;
    logic                 push_w;
    logic                 full_w;

    always_comb begin
        win_sum   = acc_sum_q + (cnt_val_i ? SUM_W'(cnt_i) : '0);
        win_min   = (cnt_val_i && (cnt_i < acc_min_q)) ? cnt_i : acc_min_q;
        win_max   = (cnt_val_i && (cnt_i > acc_max_q)) ? cnt_i : acc_max_q;
        win_words = acc_words_q + WCNT_W'(cnt_val_i);

        // A flush that coincides with the final word still yields one record,
        // since both conditions fold into the same close event.
        close_w = (cnt_val_i && (acc_words_q == WCNT_W'(WINDOW_LEN - 1)))
                || (flush_i && (win_words != '0));

        pop_w  = (occ_q != '0) && stat_ready_i;
        full_w = (occ_q == OCC_W'(FIFO_DEPTH));
        push_w = close_w && (!full_w || pop_w);
        drop_d = close_w && !push_w;

        // Closing restarts the window whether or not the record was kept
        if (close_w) begin
            acc_sum_d   = '0;
            acc_min_d   = '1;
            acc_max_d   = '0;
            acc_words_d = '0;
        end else begin
            acc_sum_d   = win_sum;
            acc_min_d   = win_min;
            acc_max_d   = win_max;
            acc_words_d = win_words;
        end

        mem_sum_d   = mem_sum_q;
        mem_min_d   = mem_min_q;
        mem_max_d   = mem_max_q;
        mem_words_d = mem_words_q;
        if (push_w) begin
            mem_sum_d[wr_ptr_q]   = win_sum;
            mem_min_d[wr_ptr_q]   = win_min;
            mem_max_d[wr_ptr_q]   = win_max;
            mem_words_d[wr_ptr_q] = win_words;
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(push_w);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_w);
        occ_d    = occ_q + OCC_W'(push_w) - OCC_W'(pop_w);

        // Outputs are loaded from the next-state head so a record pushed into
        // an empty FIFO appears one cycle after its closing word; when the
        // FIFO drains, the last shown record is held.
        out_val_d   = (occ_d != '0);
        out_sum_d   = out_sum_q;
        out_min_d   = out_min_q;
        out_max_d   = out_max_q;
        out_words_d = out_words_q;
        if (occ_d != '0) begin
            out_sum_d   = mem_sum_d[rd_ptr_d];
            out_min_d   = mem_min_d[rd_ptr_d];
            out_max_d   = mem_max_d[rd_ptr_d];
            out_words_d = mem_words_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            acc_sum_q   <= '0;
            acc_min_q   <= '1;
            acc_max_q   <= '0;
            acc_words_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_sum_q[i]   <= '0;
                mem_min_q[i]   <= '0;
                mem_max_q[i]   <= '0;
                mem_words_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            out_sum_q   <= '0;
            out_min_q   <= '0;
            out_max_q   <= '0;
            out_words_q <= '0;
            out_val_q   <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            acc_sum_q   <= acc_sum_d;
            acc_min_q   <= acc_min_d;
            acc_max_q   <= acc_max_d;
            acc_words_q <= acc_words_d;
            mem_sum_q   <= mem_sum_d;
            mem_min_q   <= mem_min_d;
            mem_max_q   <= mem_max_d;
            mem_words_q <= mem_words_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            out_sum_q   <= out_sum_d;
            out_min_q   <= out_min_d;
            out_max_q   <= out_max_d;
            out_words_q <= out_words_d;
            out_val_q   <= out_val_d;
            drop_q      <= drop_d;
        end
    end

    assign sum_o      = out_sum_q;
    assign min_o      = out_min_q;
    assign max_o      = out_max_q;
    assign words_o    = out_words_q;
    assign stat_val_o = out_val_q;
    assign drop_o     = drop_q;

endmodule
